// File: rtl/sp1_ram_arb_pkg.sv
// rtl/sp1_ram_arb_pkg.sv - shared sp1 RAM geometry defaults and round-robin helpers
package sp1_ram_arb_pkg;

    localparam int RAM_AW = 10;
    localparam int RAM_DW = 32;
    localparam int NR_MAX = 8;

    // Next round-robin start index; wraps at nr-1, not at a power of two.
    function automatic int rr_next(input int idx, input int nr);
        return (idx == nr - 1) ? 0 : idx + 1;
    endfunction

    function automatic int ptr_width(input int nr);
        return (nr > 1) ? $clog2(nr) : 1;
    endfunction

endpackage

// File: rtl/sp1_rr_pick.sv
// rtl/sp1_rr_pick.sv - rotate-priority picker: first set request at or after ptr wins
module sp1_rr_pick
    import sp1_ram_arb_pkg::*;
#(
    parameter int NR = 2,
    parameter int PW = ptr_width(NR)
) (
    input  logic [NR-1:0] i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [NR-1:0] o_gnt,
    output logic          o_any
);

    logic w_found;

    // Each candidate start index is compared against ptr so all indexing stays constant.
    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        for (int p = 0; p < NR; p++) begin
            if (i_ptr == PW'(p)) begin
                for (int k = 0; k < NR; k++) begin
                    if (!w_found && i_req[(p + k) % NR]) begin
                        o_gnt[(p + k) % NR] = 1'b1;
                        w_found             = 1'b1;
                    end
                end
            end
        end
    end

    assign o_any = |o_gnt;

endmodule

// File: rtl/sp1_ram_arb.sv
// rtl/sp1_ram_arb.sv - round-robin arbiter sharing one single-port sp1_ram among NR requesters
module sp1_ram_arb
    import sp1_ram_arb_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW,
    parameter int NR = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NR-1:0]    req,
    input  logic [NR-1:0]    req_we,
    input  logic [NR*AW-1:0] req_adrs,
    input  logic [NR*DW-1:0] req_din,
    output logic [NR-1:0]    ack,
    output logic [NR-1:0]    rvalid,
    output logic [DW-1:0]    rdata,
    output logic             ram_cs,
    output logic             ram_we,
    output logic [AW-1:0]    ram_adrs,
    output logic [DW-1:0]    ram_din,
    input  logic [DW-1:0]    ram_dout
);

    localparam int PW = ptr_width(NR);

    logic [PW-1:0] r_ptr;
    logic          r_rd_pend;
    logic [PW-1:0] r_rd_id;

    logic [NR-1:0] w_pick_gnt;
    logic          w_pick_any;
    logic [NR-1:0] w_gnt;
    logic          w_any;
    logic [PW-1:0] w_win;
    logic          w_we;
    logic [AW-1:0] w_adrs;
    logic [DW-1:0] w_din;

    sp1_rr_pick #(
        .NR (NR),
        .PW (PW)
    ) u_pick (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_gnt),
        .o_any (w_pick_any)
    );

    // Grants are masked while reset is held so the RAM never sees a select during reset.
    assign w_gnt = rst ? w_pick_gnt : '0;
    assign w_any = rst & w_pick_any;

    // AND-OR mux on the one-hot grant yields zeros toward the RAM when idle.
    always_comb begin
        w_win  = '0;
        w_we   = 1'b0;
        w_adrs = '0;
        w_din  = '0;
        for (int i = 0; i < NR; i++) begin
            if (w_gnt[i]) begin
                w_win = PW'(i);
            end
            w_we   = w_we | (w_gnt[i] & req_we[i]);
            w_adrs = w_adrs | ({AW{w_gnt[i]}} & req_adrs[i*AW +: AW]);
            w_din  = w_din | ({DW{w_gnt[i]}} & req_din[i*DW +: DW]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_rd_pend <= 1'b0;
            r_rd_id   <= '0;
        end else begin
            r_rd_pend <= w_any & ~w_we;
            if (w_any) begin
                r_ptr   <= PW'(rr_next(int'(w_win), NR));
                r_rd_id <= w_win;
            end
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NR; i++) begin
            rvalid[i] = r_rd_pend && (r_rd_id == PW'(i));
        end
    end

    assign ack      = w_gnt;
    assign ram_cs   = w_any;
    assign ram_we   = w_we;
    assign ram_adrs = w_adrs;
    assign ram_din  = w_din;
    assign rdata    = ram_dout;

endmodule

// File: tb/tb_sp1_ram_arb.sv
// tb/tb_sp1_ram_arb.sv - self-checking bench for sp1_ram_arb with a behavioural single-port RAM
module tb_sp1_ram_arb;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NR = 2;

    logic             clk;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR-1:0]    req_we;
    logic [NR*AW-1:0] req_adrs;
    logic [NR*DW-1:0] req_din;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    rvalid;
    logic [DW-1:0]    rdata;
    logic             ram_cs;
    logic             ram_we;
    logic [AW-1:0]    ram_adrs;
    logic [DW-1:0]    ram_din;
    logic [DW-1:0]    ram_dout;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_checks = 0;
    int n_errors = 0;

    sp1_ram_arb #(.AW(AW), .DW(DW), .NR(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_we   (req_we),
        .req_adrs (req_adrs),
        .req_din  (req_din),
        .ack      (ack),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_cs   (ram_cs),
        .ram_we   (ram_we),
        .ram_adrs (ram_adrs),
        .ram_din  (ram_din),
        .ram_dout (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) mem[ram_adrs] <= ram_din;
            else        ram_dout      <= mem[ram_adrs];
        end
    end

    typedef struct {
        logic [1:0]  rq;
        logic [1:0]  we;
        logic [9:0]  a0;
        logic [9:0]  a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  exp_ack;
        logic [1:0]  exp_rv;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tv[$];

    // Reference model state: abstract pointer, memory image, one-deep read pipeline.
    int          m_ptr;
    logic [31:0] m_mem [0:(1<<AW)-1];
    bit          m_pend;
    int          m_pend_id;
    logic [31:0] m_pend_data;

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] we,
                                input logic [9:0] a0, input logic [9:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] ea, input logic [1:0] erv,
                                input logic [31:0] erd);
        vec_t v;
        v.rq = rq; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.exp_ack = ea; v.exp_rv = erv; v.exp_rd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] we,
                         input logic [9:0] a0, input logic [9:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        req      = rq;
        req_we   = we;
        req_adrs = {a1, a0};
        req_din  = {d1, d0};
    endtask

    task automatic step(input logic [1:0] rq, input logic [1:0] we,
                        input logic [9:0] a0, input logic [9:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1);
        int win;
        int adr;
        logic [1:0] exp_ack;
        logic [1:0] exp_rv;
        @(negedge clk);
        drive(rq, we, a0, a1, d0, d1);
        #1;
        win = -1;
        for (int k = 0; k < NR; k++) begin
            if (win < 0 && rq[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
        end
        exp_ack = (win >= 0) ? 2'(1 << win) : 2'b00;
        exp_rv  = m_pend ? 2'(1 << m_pend_id) : 2'b00;
        check("rnd_ack", 32'(ack), 32'(exp_ack));
        check("rnd_rvalid", 32'(rvalid), 32'(exp_rv));
        if (m_pend) check("rnd_rdata", rdata, m_pend_data);
        m_pend = 1'b0;
        if (win >= 0) begin
            adr = (win == 1) ? int'(a1) : int'(a0);
            if (we[win]) begin
                m_mem[adr] = (win == 1) ? d1 : d0;
            end else begin
                m_pend      = 1'b1;
                m_pend_id   = win;
                m_pend_data = m_mem[adr];
            end
            m_ptr = (win + 1) % NR;
        end
    endtask

    initial begin
        logic [1:0]  e_ack;
        logic [9:0]  e_adrs;
        logic [31:0] e_din;
        logic        e_we;

        rst = 1'b0;
        drive(2'b11, 2'b00, 10'h100, 10'h101, 32'h0, 32'h0);

        // Reset holds grants off even with both requests active.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_cs", 32'(ram_cs), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_first_grant", 32'(ack), 32'h1);
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);

        tv.push_back(mk(2'b01, 2'b01, 10'h000, 10'h000, 32'hcafecafe, 32'h0, 2'b01, 2'b00, 32'h0));
        tv.push_back(mk(2'b01, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0));
        tv.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 2'b00, 2'b01, 32'hcafecafe));
        tv.push_back(mk(2'b10, 2'b10, 10'h000, 10'h001, 32'h0, 32'h33333333, 2'b10, 2'b00, 32'h0));
        tv.push_back(mk(2'b10, 2'b10, 10'h000, 10'h002, 32'h0, 32'hcccccccc, 2'b10, 2'b00, 32'h0));
        tv.push_back(mk(2'b10, 2'b10, 10'h000, 10'h003, 32'h0, 32'h55555555, 2'b10, 2'b00, 32'h0));
        tv.push_back(mk(2'b10, 2'b10, 10'h000, 10'h004, 32'h0, 32'haaaaaaaa, 2'b10, 2'b00, 32'h0));
        tv.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0, 2'b01, 2'b00, 32'h0));
        tv.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0, 2'b10, 2'b01, 32'h33333333));
        tv.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0, 2'b01, 2'b10, 32'hcccccccc));
        tv.push_back(mk(2'b11, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0, 2'b10, 2'b01, 32'h33333333));
        tv.push_back(mk(2'b10, 2'b00, 10'h000, 10'h001, 32'h0, 32'h0, 2'b10, 2'b10, 32'hcccccccc));
        tv.push_back(mk(2'b10, 2'b00, 10'h000, 10'h002, 32'h0, 32'h0, 2'b10, 2'b10, 32'h33333333));
        tv.push_back(mk(2'b10, 2'b00, 10'h000, 10'h003, 32'h0, 32'h0, 2'b10, 2'b10, 32'hcccccccc));
        tv.push_back(mk(2'b10, 2'b00, 10'h000, 10'h004, 32'h0, 32'h0, 2'b10, 2'b10, 32'h55555555));
        tv.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 2'b00, 2'b10, 32'haaaaaaaa));
        tv.push_back(mk(2'b01, 2'b01, 10'h3ff, 10'h000, 32'hbeefbeef, 32'h0, 2'b01, 2'b00, 32'h0));
        tv.push_back(mk(2'b10, 2'b00, 10'h000, 10'h3ff, 32'h0, 32'h0, 2'b10, 2'b00, 32'h0));
        tv.push_back(mk(2'b00, 2'b00, 10'h000, 10'h000, 32'h0, 32'h0, 2'b00, 2'b10, 32'hbeefbeef));

        foreach (tv[v]) begin
            @(negedge clk);
            drive(tv[v].rq, tv[v].we, tv[v].a0, tv[v].a1, tv[v].d0, tv[v].d1);
            #1;
            e_ack  = tv[v].exp_ack;
            e_adrs = e_ack[0] ? tv[v].a0 : (e_ack[1] ? tv[v].a1 : 10'h0);
            e_din  = e_ack[0] ? tv[v].d0 : (e_ack[1] ? tv[v].d1 : 32'h0);
            e_we   = (e_ack[0] & tv[v].we[0]) | (e_ack[1] & tv[v].we[1]);
            check($sformatf("vec%0d_ack", v), 32'(ack), 32'(e_ack));
            check($sformatf("vec%0d_rvalid", v), 32'(rvalid), 32'(tv[v].exp_rv));
            if (tv[v].exp_rv != 2'b00) check($sformatf("vec%0d_rdata", v), rdata, tv[v].exp_rd);
            check($sformatf("vec%0d_cs", v), 32'(ram_cs), 32'(|e_ack));
            check($sformatf("vec%0d_we", v), 32'(ram_we), 32'(e_we));
            check($sformatf("vec%0d_adrs", v), 32'(ram_adrs), 32'(e_adrs));
            check($sformatf("vec%0d_din", v), ram_din, e_din);
        end

        // Reset between a read grant and its rvalid cycle; ptr left at 1 beforehand.
        @(negedge clk);
        drive(2'b01, 2'b00, 10'h001, 10'h000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_rvalid", 32'(rvalid), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(2'b11, 2'b00, 10'h001, 10'h002, 32'h0, 32'h0);
        #1;
        check("midrst_release_rvalid", 32'(rvalid), 32'h0);
        check("midrst_ptr_zero", 32'(ack), 32'h1);

        @(negedge clk);
        drive(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_ptr  = 0;
        m_pend = 1'b0;

        for (int a = 0; a < 16; a++) begin
            step(2'b10, 2'b10, 10'h0, 10'(a), 32'h0, $urandom);
        end
        for (int n = 0; n < 400; n++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 10'($urandom_range(0, 15)), 10'($urandom_range(0, 15)),
                 $urandom, $urandom);
        end
        step(2'b00, 2'b00, 10'h0, 10'h0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
